reg_dump_unit: RTL and testbench



---
 rtl/reg_dump_unit_pkg.sv | 23 ++
 rtl/register_file.sv | 35 +++
 rtl/reg_dump_unit.sv | 136 +++++++++++++
 tb/tb_reg_dump_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_dump_unit_pkg
//  Description : Shared types and sizing constants for the register file and
//                its debug dump engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_dump_unit_pkg;

    // Register file geometry shared by register_file and reg_dump_unit
    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 8;

    // Dump engine states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } dump_state_t;

endpackage : reg_dump_unit_pkg
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : 2**ADDR_W x DATA_W register file, one synchronous write port
//                and one combinational read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file
    import reg_dump_unit_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

    // Storage array: writes land at the clock edge, so a read in the same
    // cycle still returns the old value
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule : register_file
`default_nettype wire

// File: rtl/reg_dump_unit.sv
`default_nettype none
// ============================================================================
//  Module      : reg_dump_unit
//  Description : Debug read-out engine. Walks a (possibly wrapping) range of
//                register addresses through one read port, snapshots each
//                value and streams (addr, data) over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_unit
    import reg_dump_unit_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] dump_first,
    input  logic [ADDR_W-1:0] dump_last,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    dump_state_t       r_state;
    dump_state_t       w_next_state;
    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W-1:0] r_last;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0] r_out_data;

    logic              w_load_range;
    logic              w_capture;
    logic              w_advance;
    logic              w_clear_valid;

    // Next-state and datapath control; abort overrides everything outside IDLE
    always_comb begin
        w_next_state  = r_state;
        w_load_range  = 1'b0;
        w_capture     = 1'b0;
        w_advance     = 1'b0;
        w_clear_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // abort arriving with start cancels the request outright
                if (start && !abort) begin
                    w_load_range = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    w_clear_valid = 1'b1;
                    w_next_state  = ST_IDLE;
                end else begin
                    w_capture    = 1'b1;
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    // word is dropped, cur stays where it was
                    w_clear_valid = 1'b1;
                    w_next_state  = ST_IDLE;
                end else if (r_out_valid && out_ready) begin
                    w_clear_valid = 1'b1;
                    if (r_cur == r_last) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_advance    = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Address counter, range latch and output word register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur       <= '0;
            r_last      <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
        end else begin
            if (w_load_range) begin
                r_cur  <= dump_first;
                r_last <= dump_last;
            end
            if (w_advance) begin
                r_cur <= r_cur + 1'b1;
            end
            if (w_capture) begin
                r_out_data  <= rf_read_data;
                r_out_addr  <= r_cur;
                r_out_valid <= 1'b1;
            end
            if (w_clear_valid) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign rf_read_addr = r_cur;
    assign out_valid    = r_out_valid;
    assign out_addr     = r_out_addr;
    assign out_data     = r_out_data;
    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);

endmodule : reg_dump_unit
`default_nettype wire

// File: tb/tb_reg_dump_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_dump_unit
//  Description : Directed self-checking bench for reg_dump_unit driven by the
//                real register_file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_dump_unit;
    import reg_dump_unit_pkg::*;

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic                  abort;
    logic [REG_ADDR_W-1:0] dump_first;
    logic [REG_ADDR_W-1:0] dump_last;
    logic [REG_ADDR_W-1:0] rf_read_addr;
    logic [REG_DATA_W-1:0] rf_read_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [REG_ADDR_W-1:0] out_addr;
    logic [REG_DATA_W-1:0] out_data;
    logic                  busy;
    logic                  done;

    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [REG_DATA_W-1:0] wr_data;

    logic [REG_DATA_W-1:0] model_mem [0:15];

    int n_total;
    int n_bad;
    int words, ndone, first_c, last_c, done_c;

    reg_dump_unit #(
        .ADDR_W(REG_ADDR_W),
        .DATA_W(REG_DATA_W)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .dump_first  (dump_first),
        .dump_last   (dump_last),
        .rf_read_addr(rf_read_addr),
        .rf_read_data(rf_read_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done)
    );

    register_file #(
        .ADDR_W(REG_ADDR_W),
        .DATA_W(REG_DATA_W)
    ) u_rf (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(rf_read_addr),
        .rd_data(rf_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs and samples sit 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_write(input logic [3:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic start_dump(input logic [3:0] f, input logic [3:0] l);
        dump_first = f;
        dump_last  = l;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Collect words until the done pulse; c0 is the cycle index after start
    task automatic collect(input logic [3:0] f, input int n, input int c0, input int budget);
        int c;
        logic [3:0] ea;
        words = 0; ndone = 0; first_c = -1; last_c = -1; done_c = -1;
        c = c0;
        while (c < budget && ndone == 0) begin
            if (out_valid) begin
                ea = f + 4'(words);
                if (words < n) begin
                    check("word_addr", 32'(out_addr), 32'(ea));
                    check("word_data", 32'(out_data), 32'(model_mem[ea]));
                end
                if (words == 0) first_c = c;
                last_c = c;
                words++;
            end
            if (done) begin
                ndone++;
                done_c = c;
            end
            tick();
            c++;
        end
        check("word_count", 32'(words), 32'(n));
        check("done_pulses", 32'(ndone), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_rfaddr"}, 32'(rf_read_addr), 32'd0);
        check({tag, "_oaddr"}, 32'(out_addr), 32'd0);
        check({tag, "_odata"}, 32'(out_data), 32'd0);
    endtask

    initial begin
        n_total = 0; n_bad = 0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        dump_first = '0; dump_last = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        tick(); tick();
        reset = 1'b0;
        check_idle_zero("reset");

        for (int i = 0; i < 16; i++) rf_write(4'(i), 8'hA0 + 8'(i));

        // Full dump, 0..15, sink always ready
        out_ready = 1'b1;
        start_dump(4'd0, 4'd15);
        check("full_fetch_busy", 32'(busy), 32'd1);
        check("full_fetch_valid", 32'(out_valid), 32'd0);
        check("full_fetch_rfaddr", 32'(rf_read_addr), 32'd0);
        collect(4'd0, 16, 1, 60);
        check("full_first_valid_cycle", 32'(first_c), 32'd2);
        check("full_last_accept_cycle", 32'(last_c), 32'd32);
        check("full_done_cycle", 32'(done_c), 32'd33);

        // Wrap range 14,15,0,1
        start_dump(4'd14, 4'd1);
        collect(4'd14, 4, 1, 30);

        // Backpressure on a single word
        rf_write(4'd5, 8'h3C);
        out_ready = 1'b0;
        start_dump(4'd5, 4'd5);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_addr", 32'(out_addr), 32'd5);
            check("bp_data", 32'(out_data), 32'h3C);
            if (i < 3) tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_done", 32'(done), 32'd1);
        check("bp_valid_low", 32'(out_valid), 32'd0);
        tick();
        check("bp_idle", 32'(busy), 32'd0);

        // Snapshot: overwrite the register while its word waits in SEND
        rf_write(4'd3, 8'h11);
        out_ready = 1'b0;
        start_dump(4'd3, 4'd3);
        tick();
        check("snap_before", 32'(out_data), 32'h11);
        rf_write(4'd3, 8'h22);
        check("snap_after_write", 32'(out_data), 32'h11);
        check("snap_addr", 32'(out_addr), 32'd3);
        out_ready = 1'b1;
        tick();
        check("snap_done", 32'(done), 32'd1);
        tick();
        start_dump(4'd3, 4'd3);
        collect(4'd3, 1, 1, 10);

        // Abort in SEND together with a handshake
        out_ready = 1'b1;
        start_dump(4'd0, 4'd15);
        tick();
        check("abort_pre_valid", 32'(out_valid), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_cur_kept", 32'(rf_read_addr), 32'd0);
        tick();
        check("abort_no_done", 32'(done), 32'd0);
        start_dump(4'd2, 4'd2);
        collect(4'd2, 1, 1, 10);

        // start and abort together in IDLE
        dump_first = 4'd7; dump_last = 4'd7;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", 32'(busy), 32'd0);

        // Reset in the middle of a dump
        out_ready = 1'b1;
        start_dump(4'd0, 4'd15);
        repeat (5) tick();
        check("midreset_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_zero("midreset");

        // start while busy must not disturb the range in progress
        out_ready = 1'b0;
        start_dump(4'd4, 4'd6);
        tick();
        dump_first = 4'd10; dump_last = 4'd12;
        start = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        collect(4'd4, 3, 3, 20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_reg_dump_unit
`default_nettype wire
